// File: rtl/program_rom_server.sv
// rtl/program_rom_server.sv - wait-stated program ROM with a sequential load port.
// Optional per-word parity checking is enabled by defining PROGRAM_ROM_SERVER_PARITY_EN.
module program_rom_server #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [7:0]  FILL        = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_cs,
    input  logic        rom_rd,
    input  logic [15:0] addr,
    output logic [7:0]  instruction,
    output logic        ready,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic [15:0] fetch_count
`ifdef PROGRAM_ROM_SERVER_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [7:0]    r_mem [DEPTH];
    logic [15:0]   r_addr;
    logic [2:0]    r_wait;
    logic [PW-1:0] r_ptr;
    logic [7:0]    r_instr;
    logic          r_ready;
    logic [15:0]   r_fetch_count;

    logic          w_req;
    logic          w_addr_changed;
    logic          w_latch;
    logic          w_dec;
    logic          w_fire;
    logic          w_ptr_clr;
    logic          w_ptr_ok;
    logic          w_wr;
    logic          w_in_range;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic [7:0]    w_word;

    assign w_req          = rom_cs && rom_rd;
    assign w_addr_changed = (addr != r_addr);
    assign w_in_range     = ({1'b0, r_addr} < 17'(DEPTH));
    assign w_rd_idx       = r_addr[AW-1:0];
    assign w_wr_idx       = r_ptr[AW-1:0];
    assign w_word         = w_in_range ? r_mem[w_rd_idx] : FILL;
    assign w_ptr_ok       = (r_ptr < PW'(DEPTH));
    assign w_wr           = (r_state == LOAD) && load_valid && w_ptr_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The last WAIT cycle (counter at zero) performs the synchronous memory
    // read, so ready rises WAIT_STATES+1 cycles after the request is sampled.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_dec        = 1'b0;
        w_fire       = 1'b0;
        w_ptr_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_en) begin
                    w_next_state = LOAD;
                    w_ptr_clr    = 1'b1;
                end else if (w_req) begin
                    w_next_state = WAIT;
                    w_latch      = 1'b1;
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (w_addr_changed) begin
                    w_latch = 1'b1;
                end else if (r_wait == 3'd0) begin
                    w_next_state = DRIVE;
                    w_fire       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DRIVE: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (w_addr_changed) begin
                    w_next_state = WAIT;
                    w_latch      = 1'b1;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr        <= 16'h0000;
            r_wait        <= 3'd0;
            r_ptr         <= '0;
            r_instr       <= 8'h00;
            r_ready       <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else begin
            if (w_latch) begin
                r_addr <= addr;
                r_wait <= 3'(WAIT_STATES);
            end else if (w_dec) begin
                r_wait <= r_wait - 3'd1;
            end

            if (w_ptr_clr) begin
                r_ptr <= '0;
            end else if (w_wr) begin
                r_ptr <= r_ptr + PW'(1);
            end

            if (w_fire) begin
                r_instr <= w_word;
                if (r_fetch_count != 16'hFFFF) begin
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
            end

            r_ready <= (w_next_state == DRIVE);
        end
    end

    // Storage is deliberately outside the reset domain so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_wr_idx] <= load_data;
        end
    end

`ifdef PROGRAM_ROM_SERVER_PARITY_EN
    logic r_par [DEPTH];
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_par[w_wr_idx] <= ^load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else if (w_fire) begin
            r_parity_err <= w_in_range && ((^r_mem[w_rd_idx]) != r_par[w_rd_idx]);
        end else if (w_next_state != DRIVE) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign instruction = r_instr;
    assign ready       = r_ready;
    assign load_ready  = (r_state == LOAD) && w_ptr_ok;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_program_rom_server.sv
// tb/tb_program_rom_server.sv - randomized bench for program_rom_server against an age-based reference model.
module tb_program_rom_server;

    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam logic [7:0] FILL = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rom_cs = 1'b0;
    logic        rom_rd = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  instruction;
    logic        ready;
    logic        load_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_ready;
    logic [15:0] fetch_count;
`ifdef PROGRAM_ROM_SERVER_PARITY_EN
    logic        parity_err;
    bit          par_inject = 1'b0;
`endif

    program_rom_server #(.DEPTH(DEPTH), .WAIT_STATES(WS), .FILL(FILL)) dut (
        .clk(clk), .reset(reset), .rom_cs(rom_cs), .rom_rd(rom_rd), .addr(addr),
        .instruction(instruction), .ready(ready), .load_en(load_en),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .fetch_count(fetch_count)
`ifdef PROGRAM_ROM_SERVER_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: mode 0 = quiet, 1 = serving a fetch, 2 = loading.
    // A fetch is described by its age in cycles since the request was sampled.
    int          m_mode = 0;
    int          m_age = 0;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_instr = 8'h00;
    bit          m_iknown = 1'b1;
    logic [15:0] m_fc = 16'h0000;
    int          m_ptr = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_age = 0; m_instr = 8'h00; m_iknown = 1'b1;
            m_fc = 16'h0000; m_ptr = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (load_en) begin
                        m_mode = 2; m_ptr = 0;
                    end else if (rom_cs && rom_rd) begin
                        m_mode = 1; m_addr = addr; m_age = 0;
                    end
                end
                1: begin
                    if (!(rom_cs && rom_rd)) begin
                        m_mode = 0;
                    end else if (addr != m_addr) begin
                        m_addr = addr; m_age = 0;
                    end else if (m_age <= WS) begin
                        m_age++;
                        if (m_age == WS + 1) begin
                            if (int'(m_addr) >= DEPTH) begin
                                m_instr = FILL; m_iknown = 1'b1;
                            end else begin
                                m_instr = m_mem[m_addr]; m_iknown = m_known[m_addr];
                            end
                            if (m_fc != 16'hFFFF) m_fc++;
                        end
                    end
                end
                default: begin
                    if (load_valid && m_ptr < DEPTH) begin
                        m_mem[m_ptr] = load_data; m_known[m_ptr] = 1'b1; m_ptr++;
                    end
                    if (!load_en) m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ready", ready, (m_mode == 1 && m_age == WS + 1));
            chk("load_ready", load_ready, (m_mode == 2 && m_ptr < DEPTH));
            chk("fetch_count", fetch_count, m_fc);
            if (m_iknown) chk("instruction", instruction, m_instr);
`ifdef PROGRAM_ROM_SERVER_PARITY_EN
            if (!par_inject) chk("parity_err", parity_err, 1'b0);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_on(input logic [15:0] a);
        rom_cs = 1'b1; rom_rd = 1'b1; addr = a;
    endtask

    initial begin
        cmp_on = 1'b1;
        step(2);
        chk("rst_ready", ready, 1'b0);
        chk("rst_instr", instruction, 8'h00);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_fetch_count", fetch_count, 16'h0);
        reset = 1'b1;
        step(1);

        // Load two words, then fetch address 1.
        load_en = 1'b1;
        step(1);
        chk("load_entry_ready", load_ready, 1'b1);
        load_valid = 1'b1; load_data = 8'hA5;
        step(1);
        load_data = 8'h3C;
        step(1);
        load_valid = 1'b0; load_en = 1'b0;
        step(1);
        rd_on(16'h0001);
        step(1); chk("lat_1", ready, 1'b0);
        step(1); chk("lat_2", ready, 1'b0);
        step(1); chk("lat_3", ready, 1'b1);
        chk("first_instr", instruction, 8'h3C);
        chk("first_fc", fetch_count, 16'd1);
        chk("model_instr", m_instr, 8'h3C);

        // load_en is ignored while a fetch is being served.
        load_en = 1'b1;
        step(1);
        chk("drive_ignores_load_en", ready, 1'b1);
        chk("drive_no_load_ready", load_ready, 1'b0);
        load_en = 1'b0;

        // Address changes in DRIVE restart the fetch.
        addr = 16'h0000;
        step(1); chk("chg0_ready_a", ready, 1'b0);
        step(1); chk("chg0_ready_b", ready, 1'b0);
        step(1); chk("chg0_ready_c", ready, 1'b1);
        chk("chg0_instr", instruction, 8'hA5);
        addr = 16'h0001;
        step(1); chk("chg1_ready_a", ready, 1'b0);
        step(2); chk("chg1_ready_c", ready, 1'b1);
        chk("chg1_instr", instruction, 8'h3C);
        chk("chg1_fc", fetch_count, 16'd3);
        rom_cs = 1'b0;
        step(1);
        chk("drop_ready", ready, 1'b0);
        chk("drop_instr_hold", instruction, 8'h3C);

        // Out-of-range address returns FILL.
        rd_on(16'h0200);
        step(3);
        chk("fill_ready", ready, 1'b1);
        chk("fill_instr", instruction, FILL);
        chk("fill_fc", fetch_count, 16'd4);
        rom_cs = 1'b0; rom_rd = 1'b0;
        step(1);

        // Reset in the middle of a wait.
        rd_on(16'h0000);
        step(1);
        reset = 1'b0;
        #1;
        chk("midwait_rst_ready", ready, 1'b0);
        chk("midwait_rst_instr", instruction, 8'h00);
        chk("midwait_rst_fc", fetch_count, 16'd0);
        rom_cs = 1'b0; rom_rd = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        rd_on(16'h0000);
        step(3);
        chk("post_rst_ready", ready, 1'b1);
        chk("post_rst_instr", instruction, 8'hA5);
        rom_cs = 1'b0; rom_rd = 1'b0;
        step(1);

        // Overfill the store by one word.
        load_en = 1'b1;
        step(1);
        for (int i = 0; i <= DEPTH; i++) begin
            load_valid = 1'b1;
            load_data = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : (i == DEPTH) ? 8'h5A : 8'($urandom);
            chk("fill_load_ready", load_ready, (i < DEPTH));
            step(1);
        end
        load_valid = 1'b0; load_en = 1'b0;
        step(1);
        rd_on(16'h0000);
        step(3);
        chk("no_wrap_mem0", instruction, 8'hA5);
        rom_cs = 1'b0;
        step(1);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                load_en = 1'b1;
                step(1);
                for (int k = 0; k < int'($urandom_range(0, 20)); k++) begin
                    load_valid = 1'($urandom);
                    load_data = 8'($urandom);
                    step(1);
                end
                load_valid = 1'b0; load_en = 1'b0;
                step(1);
            end else begin
                rd_on(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1)));
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                    if ($urandom_range(0, 4) == 0) addr = 16'($urandom_range(0, DEPTH + 40));
                    load_en = ($urandom_range(0, 9) == 0);
                    step(1);
                end
                load_en = 1'b0;
                if ($urandom_range(0, 1) == 0) begin
                    rom_cs = 1'($urandom);
                    rom_rd = rom_cs ? 1'b0 : 1'($urandom);
                    step($urandom_range(1, 2));
                end
            end
        end
        rom_cs = 1'b0; rom_rd = 1'b0; load_en = 1'b0;
        step(2);

`ifdef PROGRAM_ROM_SERVER_PARITY_EN
        par_inject = 1'b1;
        dut.r_par[1] = ~dut.r_par[1];
        rd_on(16'h0001);
        step(3);
        chk("parity_ready", ready, 1'b1);
        chk("parity_err", parity_err, 1'b1);
        rom_cs = 1'b0;
        step(1);
`endif

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
